if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives the instruction memory request, tracks the PC,
// and presents fetched words to the IF/ID register. It supports stalls, redirects
// and discarding a fetch that is still in flight.
// Optional build macro PERF_CNT_EN adds the perf_fetch_cnt and perf_stall_cnt counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_PC_out,
  output logic        IF_valid,
  output logic        IF_Flush
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_DISCARD = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_inst;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] target_aligned;

  // Redirect targets are always word aligned
  assign target_aligned = branch_target & ~XLEN'(3);

  // Memory request is live except while parking a returned word; silent in reset
  assign imem_req  = reset & (state != S_HOLD);
  assign imem_addr = pc;
  assign IF_Flush  = reset & PCSrc;

  // Fetch FSM together with the PC, the hold/target registers and the IF outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      hold_inst <= '0;
      hold_pc   <= '0;
      target_q  <= '0;
      IF_inst   <= '0;
      IF_PC_out <= '0;
      IF_valid  <= 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (PCSrc) begin
            IF_inst  <= '0;
            IF_valid <= 1'b0;
            if (imem_ready) begin
              pc <= target_aligned;
            end else begin
              target_q <= target_aligned;
              state    <= S_DISCARD;
            end
          end else if (imem_ready) begin
            if (PCWrite) begin
              IF_inst   <= imem_rdata;
              IF_PC_out <= pc;
              IF_valid  <= 1'b1;
              pc        <= pc + PC_STEP;
            end else begin
              hold_inst <= imem_rdata;
              hold_pc   <= pc;
              state     <= S_HOLD;
            end
          end else if (PCWrite) begin
            IF_inst  <= '0;
            IF_valid <= 1'b0;
          end
        end
        S_DISCARD: begin
          if (PCSrc) begin
            IF_inst  <= '0;
            IF_valid <= 1'b0;
            if (imem_ready) begin
              pc    <= target_aligned;
              state <= S_REQ;
            end else begin
              target_q <= target_aligned;
            end
          end else if (imem_ready) begin
            pc    <= target_q;
            state <= S_REQ;
          end
        end
        S_HOLD: begin
          if (PCSrc) begin
            IF_inst  <= '0;
            IF_valid <= 1'b0;
            pc       <= target_aligned;
            state    <= S_REQ;
          end else if (PCWrite) begin
            IF_inst   <= hold_inst;
            IF_PC_out <= hold_pc;
            IF_valid  <= 1'b1;
            pc        <= pc + PC_STEP;
            state     <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic deliver_c;

  // An instruction reaches IF/ID this cycle
  assign deliver_c = ~PCSrc & PCWrite &
                     (((state == S_REQ) & imem_ready) | (state == S_HOLD));

  // Free-running delivery and stall counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (deliver_c) perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
      if (!PCWrite)  perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a reference model of the fetch rules checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCWrite = 1'b1;
  logic        PCSrc = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] IF_inst;
  logic [31:0] IF_PC_out;
  logic        IF_valid;
  logic        IF_Flush;
`ifdef PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .IF_inst(IF_inst),
    .IF_PC_out(IF_PC_out), .IF_valid(IF_valid), .IF_Flush(IF_Flush)
`ifdef PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a pure function of the address
  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = memw(imem_addr);

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the PC, the presented instruction, an optional parked word,
  // and an optional pending redirect.
  logic [31:0] m_pc, m_inst, m_ipc, m_tgt, m_fetch, m_stall;
  logic        m_valid, m_held, m_redir;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc <= RESET_PC; m_inst <= '0; m_ipc <= '0; m_valid <= 1'b0;
      m_held <= 1'b0; m_redir <= 1'b0; m_tgt <= '0; m_fetch <= '0; m_stall <= '0;
    end else begin
      if (!PCWrite) m_stall <= m_stall + 32'd1;
      if (PCSrc) begin
        m_inst <= '0; m_valid <= 1'b0;
        if (m_held || imem_ready) begin
          m_pc <= {branch_target[31:2], 2'b00}; m_held <= 1'b0; m_redir <= 1'b0;
        end else begin
          m_redir <= 1'b1; m_tgt <= {branch_target[31:2], 2'b00};
        end
      end else if (m_redir) begin
        if (imem_ready) begin m_pc <= m_tgt; m_redir <= 1'b0; end
      end else if (m_held) begin
        if (PCWrite) begin
          m_inst <= memw(m_pc); m_ipc <= m_pc; m_valid <= 1'b1;
          m_pc <= m_pc + 32'd4; m_held <= 1'b0; m_fetch <= m_fetch + 32'd1;
        end
      end else if (imem_ready) begin
        if (PCWrite) begin
          m_inst <= memw(m_pc); m_ipc <= m_pc; m_valid <= 1'b1;
          m_pc <= m_pc + 32'd4; m_fetch <= m_fetch + 32'd1;
        end else begin
          m_held <= 1'b1;
        end
      end else if (PCWrite) begin
        m_inst <= '0; m_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    check32("m_IF_inst", IF_inst, m_inst);
    check32("m_IF_PC_out", IF_PC_out, m_ipc);
    check32("m_IF_valid", 32'(IF_valid), 32'(m_valid));
    check32("m_imem_req", 32'(imem_req), 32'(reset && !m_held));
    check32("m_IF_Flush", 32'(IF_Flush), 32'(reset && PCSrc));
    if (reset && !m_held) check32("m_imem_addr", imem_addr, m_pc);
`ifdef PERF_CNT_EN
    check32("m_perf_fetch", perf_fetch_cnt, m_fetch);
    check32("m_perf_stall", perf_stall_cnt, m_stall);
`endif
  end

  task automatic drive(input logic w, input logic s, input logic r, input logic [31:0] t);
    PCWrite = w; PCSrc = s; imem_ready = r; branch_target = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic w, input logic s, input logic r, input logic [31:0] t);
    drive(w, s, r, t);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_valid", 32'(IF_valid), 32'd0);
    check32("rst_pc_out", IF_PC_out, 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Streaming fetch from reset
    cyc(1, 0, 1, 0);
    check32("s0_pc", IF_PC_out, 32'h0);
    check32("s0_inst", IF_inst, 32'hDEAD_0000);
    check32("s0_valid", 32'(IF_valid), 32'd1);
    cyc(1, 0, 1, 0);
    check32("s1_pc", IF_PC_out, 32'h4);

    // Memory not ready for three cycles at 8
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      check32("bub_valid", 32'(IF_valid), 32'd0);
      check32("bub_addr", imem_addr, 32'h8);
    end
    cyc(1, 0, 1, 0);
    check32("s2_pc", IF_PC_out, 32'h8);
    check32("s2_inst", IF_inst, 32'hDEAD_0008);

    // Stall while the word at C returns
    cyc(0, 0, 1, 0);
    check32("hold_pc0", IF_PC_out, 32'h8);
    check32("hold_req0", 32'(imem_req), 32'd0);
    cyc(0, 0, 0, 0);
    check32("hold_pc1", IF_PC_out, 32'h8);
    check32("hold_req1", 32'(imem_req), 32'd0);
    cyc(1, 0, 0, 0);
    check32("rel_pc", IF_PC_out, 32'hC);
    check32("rel_inst", IF_inst, 32'hDEAD_000C);
    check32("rel_addr", imem_addr, 32'h10);

    // Stall with memory not ready: outputs frozen
    cyc(0, 0, 0, 0);
    check32("frz_valid", 32'(IF_valid), 32'd1);
    check32("frz_addr", imem_addr, 32'h10);

    // Redirect to 0x41 while the fetch at 0x10 is outstanding
    drive(1, 1, 0, 32'h41);
    #1 check32("br_flush", 32'(IF_Flush), 32'd1);
    tick();
    check32("br_valid", 32'(IF_valid), 32'd0);
    check32("br_inst", IF_inst, 32'h0);
    check32("br_old_addr", imem_addr, 32'h10);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    check32("br_drop_valid", 32'(IF_valid), 32'd0);
    check32("br_new_addr", imem_addr, 32'h40);
    cyc(1, 0, 1, 0);
    check32("br_pc", IF_PC_out, 32'h40);

    // Redirect out of a parked word
    cyc(0, 0, 1, 0);
    drive(0, 1, 0, 32'h100);
    #1 check32("hb_flush", 32'(IF_Flush), 32'd1);
    tick();
    check32("hb_addr", imem_addr, 32'h100);
    check32("hb_valid", 32'(IF_valid), 32'd0);

    // Redirect with data returning, then a retargeted pending redirect
    cyc(1, 1, 1, 32'h203);
    check32("rb_addr", imem_addr, 32'h200);
    cyc(1, 1, 0, 32'h300);
    cyc(1, 1, 0, 32'h400);
    check32("ov_old_addr", imem_addr, 32'h200);
    cyc(1, 0, 1, 0);
    check32("ov_addr", imem_addr, 32'h400);

    // PC wrap at the top of the address space
    cyc(1, 1, 1, 32'hFFFF_FFFF);
    check32("wr_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 1, 0);
    check32("wr_pc", IF_PC_out, 32'hFFFF_FFFC);
    check32("wr_next", imem_addr, 32'h0);

    // Reset during a stall
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset = 1'b0;
    drive(1, 1, 1, 32'h500);
    #1;
    check32("mr_inst", IF_inst, 32'h0);
    check32("mr_pc", IF_PC_out, 32'h0);
    check32("mr_valid", 32'(IF_valid), 32'd0);
    check32("mr_req", 32'(imem_req), 32'd0);
    check32("mr_flush", 32'(IF_Flush), 32'd0);
    tick();
    drive(1, 0, 1, 0);
    reset = 1'b1;
    #1;
    check32("mr_restart_addr", imem_addr, RESET_PC);
    check32("mr_restart_req", 32'(imem_req), 32'd1);

    // Five deliveries interleaved with three stalls
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    check32("pf_pc", IF_PC_out, 32'h10);
`ifdef PERF_CNT_EN
    check32("pf_fetch", perf_fetch_cnt, 32'd5);
    check32("pf_stall", perf_stall_cnt, 32'd3);
`endif
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
